// File: rtl/gumnut_port_pkg.sv
// Shared definitions for the Gumnut I/O port responder: register offsets,
// control/status bit positions and the bus handshake state encoding.
package gumnut_port_pkg;

  localparam logic [2:0] OFF_LED     = 3'd0;
  localparam logic [2:0] OFF_SWIN    = 3'd1;
  localparam logic [2:0] OFF_TCTRL   = 3'd2;
  localparam logic [2:0] OFF_TRELOAD = 3'd3;
  localparam logic [2:0] OFF_TCOUNT  = 3'd4;
  localparam logic [2:0] OFF_STATUS  = 3'd5;

  localparam int TCTRL_EN       = 0;
  localparam int TCTRL_IRQ_EN   = 1;
  localparam int TCTRL_AUTO     = 2;
  localparam int STATUS_EXPIRED = 0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} port_state_t;

endpackage

// File: rtl/gumnut_port_timer.sv
// Prescaled 8-bit down-count timer: owns the enable bit, reload value,
// current count and the sticky expiry flag.
module port_timer #(
  parameter int PRESC_DIV = 16
) (
  input  logic       clkg,
  input  logic       rst,
  input  logic       ctrl_wr_i,
  input  logic       ctrl_en_i,
  input  logic       auto_reload_i,
  input  logic       reload_wr_i,
  input  logic [7:0] reload_dat_i,
  input  logic       clr_i,
  output logic       en_o,
  output logic [7:0] reload_o,
  output logic [7:0] count_o,
  output logic       expired_o
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    count_q, count_d;
  logic [7:0]    reload_q, reload_d;
  logic          en_q, en_d;
  logic          exp_q, exp_d;
  logic          tick;
  logic          expiry;

  assign tick   = en_q && (presc_q == PRESC_LAST);
  assign expiry = tick && (count_q == 8'd0);

  always_comb begin
    presc_d  = presc_q;
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    exp_d    = exp_q;

    if (en_q) presc_d = tick ? '0 : presc_q + 1'b1;

    if (tick && count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end else if (expiry) begin
      if (auto_reload_i) count_d = reload_q;
      else               en_d    = 1'b0;
    end

    // Expiry beats any clear arriving on the same edge.
    if (expiry)     exp_d = 1'b1;
    else if (clr_i) exp_d = 1'b0;

    // Bus writes override whatever the timer decided this cycle.
    if (ctrl_wr_i) en_d = ctrl_en_i;
    if (reload_wr_i) begin
      reload_d = reload_dat_i;
      count_d  = reload_dat_i;
      presc_d  = '0;
    end
  end

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      count_q  <= '0;
      reload_q <= '0;
      en_q     <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      exp_q    <= exp_d;
    end
  end

  assign en_o      = en_q;
  assign reload_o  = reload_q;
  assign count_o   = count_q;
  assign expired_o = exp_q;

endmodule

// File: rtl/gumnut_port_responder.sv
// Responder end of the Gumnut port bus: window decode, handshake FSM,
// LED/switch/timer register file and a registered interrupt request.
module gumnut_port_responder
  import gumnut_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'h00,
  parameter int         WAIT_STATES = 0,
  parameter int         PRESC_DIV   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clkg,
  input  logic        rst,
  input  logic        port_cyc_i,
  input  logic        port_stb_i,
  input  logic        port_we_i,
  input  logic [7:0]  port_adr_i,
  input  logic [7:0]  port_dat_i,
  output logic [7:0]  port_dat_o,
  output logic        port_ack_o,
  input  logic [7:0]  sw_i,
  output logic [7:0]  led_o,
  output logic        int_req_o,
  input  logic        int_ack_i,
  output port_state_t dbg_state_o
);

  // Bus contract: a request is cyc & stb & in-window address, sampled on one
  // clkg edge; address/data/we are frozen then. ack is a one-cycle pulse with
  // port_dat_o valid alongside it. The initiator must drop stb to release HOLD.

  localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

  port_state_t state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [2:0]  adr_q, adr_d;
  logic [7:0]  wd_q, wd_d;
  logic        we_q, we_d;
  logic        ack_q;
  logic [7:0]  dat_q;

  logic        req;
  logic [2:0]  rd_off;
  logic [7:0]  rd_data;
  logic        wr;

  logic [7:0]  led_q;
  logic        irq_en_q;
  logic        auto_q;
  logic        int_req_q;
  logic [SYNC_STAGES-1:0][7:0] sync_q;

  logic        t_en;
  logic [7:0]  t_reload;
  logic [7:0]  t_count;
  logic        t_expired;

  assign req = port_cyc_i && port_stb_i && (port_adr_i[7:3] == BASE_ADDR[7:3]);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    adr_d   = adr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    case (state_q)
      IDLE: if (req) begin
        adr_d   = port_adr_i[2:0];
        wd_d    = port_dat_i;
        we_d    = port_we_i;
        wcnt_d  = '0;
        state_d = (WAIT_STATES == 0) ? ACK : WAIT;
      end
      WAIT: begin
        if (!(port_cyc_i && port_stb_i)) state_d = IDLE;
        else if (wcnt_q == WS_LAST)      state_d = ACK;
        else                             wcnt_d  = wcnt_q + 3'd1;
      end
      ACK:     state_d = HOLD;
      HOLD:    if (!port_stb_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data is sampled on the edge that enters ACK; from IDLE the address
  // is still only on the bus, not yet in adr_q.
  assign rd_off = (state_q == IDLE) ? port_adr_i[2:0] : adr_q;

  always_comb begin
    rd_data = 8'h00;
    case (rd_off)
      OFF_LED:     rd_data = led_q;
      OFF_SWIN:    rd_data = sync_q[SYNC_STAGES-1];
      OFF_TCTRL:   rd_data = {5'b0, auto_q, irq_en_q, t_en};
      OFF_TRELOAD: rd_data = t_reload;
      OFF_TCOUNT:  rd_data = t_count;
      OFF_STATUS:  rd_data = {7'b0, t_expired};
      default:     rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      adr_q   <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      adr_q   <= adr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      ack_q   <= (state_d == ACK);
      dat_q   <= (state_d == ACK) ? rd_data : 8'h00;
    end
  end

  assign wr = (state_q == ACK) && we_q;

  always_ff @(posedge clkg or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      irq_en_q  <= 1'b0;
      auto_q    <= 1'b0;
      int_req_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      if (wr && adr_q == OFF_LED) led_q <= wd_q;
      if (wr && adr_q == OFF_TCTRL) begin
        irq_en_q <= wd_q[TCTRL_IRQ_EN];
        auto_q   <= wd_q[TCTRL_AUTO];
      end
      int_req_q <= t_expired && irq_en_q;
      sync_q[0] <= sw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  port_timer #(.PRESC_DIV(PRESC_DIV)) u_timer (
    .clkg          (clkg),
    .rst           (rst),
    .ctrl_wr_i     (wr && adr_q == OFF_TCTRL),
    .ctrl_en_i     (wd_q[TCTRL_EN]),
    .auto_reload_i (auto_q),
    .reload_wr_i   (wr && adr_q == OFF_TRELOAD),
    .reload_dat_i  (wd_q),
    .clr_i         ((wr && adr_q == OFF_STATUS && wd_q[STATUS_EXPIRED]) || int_ack_i),
    .en_o          (t_en),
    .reload_o      (t_reload),
    .count_o       (t_count),
    .expired_o     (t_expired)
  );

  assign port_ack_o  = ack_q;
  assign port_dat_o  = dat_q;
  assign led_o       = led_q;
  assign int_req_o   = int_req_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gumnut_port_responder.sv
// Directed bench: one responder with no wait states, one with three, sharing
// clock, reset and switch inputs.
module tb_gumnut_port_responder;
  import gumnut_port_pkg::*;

  localparam logic [7:0] BASE = 8'h40;
  localparam int         PDIV = 4;

  logic        clkg = 1'b0;
  logic        rst;
  logic [7:0]  sw;
  logic        cyc[2], stb[2], we[2], ack[2], int_req[2], int_ack[2];
  logic [7:0]  adr[2], wdat[2], rdat[2], led[2];
  port_state_t dbg[2];

  int cyc_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_ack_cnt = 0;

  always #5 clkg = ~clkg;
  always @(posedge clkg) cyc_cnt <= cyc_cnt + 1;

  gumnut_port_responder #(.BASE_ADDR(BASE), .WAIT_STATES(0), .PRESC_DIV(PDIV), .SYNC_STAGES(2)) u_ws0 (
    .clkg(clkg), .rst(rst), .port_cyc_i(cyc[0]), .port_stb_i(stb[0]), .port_we_i(we[0]),
    .port_adr_i(adr[0]), .port_dat_i(wdat[0]), .port_dat_o(rdat[0]), .port_ack_o(ack[0]),
    .sw_i(sw), .led_o(led[0]), .int_req_o(int_req[0]), .int_ack_i(int_ack[0]),
    .dbg_state_o(dbg[0]));

  gumnut_port_responder #(.BASE_ADDR(BASE), .WAIT_STATES(3), .PRESC_DIV(PDIV), .SYNC_STAGES(2)) u_ws3 (
    .clkg(clkg), .rst(rst), .port_cyc_i(cyc[1]), .port_stb_i(stb[1]), .port_we_i(we[1]),
    .port_adr_i(adr[1]), .port_dat_i(wdat[1]), .port_dat_o(rdat[1]), .port_ack_o(ack[1]),
    .sw_i(sw), .led_o(led[1]), .int_req_o(int_req[1]), .int_ack_i(int_ack[1]),
    .dbg_state_o(dbg[1]));

  typedef struct {
    logic       we;
    logic [2:0] off;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc_cnt < t) @(negedge clkg);
  endtask

  // Called at a negedge; the request is sampled on the following posedge.
  task automatic access(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                        input int ws, output logic [7:0] rd);
    int  c0;
    bit  got;
    c0 = cyc_cnt;
    got = 0;
    rd = 8'h00;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clkg);
      if (ack[d] === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("ack_latency", cyc_cnt - c0 - 1, ws);
      rd = rdat[d];
      last_ack_cnt = cyc_cnt;
      @(negedge clkg);
      check("ack_one_cycle", ack[d], 0);
      check("hold_state", dbg[d], HOLD);
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(negedge clkg);
    check("idle_after_hold", dbg[d], IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int         e;
    bit         seen;

    tbl[0]  = '{1'b1, OFF_LED,     8'hA5, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, OFF_LED,     8'h00, 1'b1, 8'hA5};
    tbl[2]  = '{1'b1, OFF_TCTRL,   8'hF6, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, OFF_TCTRL,   8'h00, 1'b1, 8'h06};
    tbl[4]  = '{1'b0, OFF_STATUS,  8'h00, 1'b1, 8'h00};
    tbl[5]  = '{1'b1, 3'd6,        8'hFF, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 3'd6,        8'h00, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 3'd7,        8'h00, 1'b1, 8'h00};
    tbl[8]  = '{1'b1, OFF_TRELOAD, 8'h5A, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, OFF_TRELOAD, 8'h00, 1'b1, 8'h5A};
    tbl[10] = '{1'b0, OFF_TCOUNT,  8'h00, 1'b1, 8'h5A};
    tbl[11] = '{1'b1, OFF_TCTRL,   8'h00, 1'b0, 8'h00};

    // Clock / reset
    rst = 1'b1;
    sw  = 8'h00;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = 0; wdat[d] = 0; int_ack[d] = 0;
    end
    repeat (3) @(negedge clkg);
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", ack[d], 0);
      check("rst_dat", rdat[d], 0);
      check("rst_led", led[d], 0);
      check("rst_int", int_req[d], 0);
      check("rst_state", dbg[d], IDLE);
    end
    rst = 1'b0;
    @(negedge clkg);

    // Register file through the zero-wait responder
    for (int i = 0; i < 12; i++) begin
      access(0, tbl[i].we, BASE | {5'b0, tbl[i].off}, tbl[i].wd, 0, rd);
      if (tbl[i].chk) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      if (i == 0) check("led_after_write", led[0], 8'hA5);
    end

    // Switch synchroniser: an immediate read still sees the old value
    sw = 8'h3C;
    access(0, 1'b0, BASE | 8'd1, 8'h00, 0, rd);
    check("swin_not_yet", rd, 8'h00);
    repeat (2) @(negedge clkg);
    access(0, 1'b0, BASE | 8'd1, 8'h00, 0, rd);
    check("swin_synced", rd, 8'h3C);

    // One-shot timer: reload 3, prescale 4 -> expiry 16 cycles after enable
    access(0, 1'b1, BASE | 8'd3, 8'h03, 0, rd);
    access(0, 1'b1, BASE | 8'd2, 8'h03, 0, rd);
    e = last_ack_cnt + 1;
    wait_until(e + 16);
    check("oneshot_int_not_early", int_req[0], 0);
    wait_until(e + 17);
    check("oneshot_int_rise", int_req[0], 1);
    int_ack[0] = 1'b1;
    @(negedge clkg);
    int_ack[0] = 1'b0;
    @(negedge clkg);
    check("oneshot_int_ack_clears", int_req[0], 0);
    access(0, 1'b0, BASE | 8'd2, 8'h00, 0, rd);
    check("oneshot_en_autoclear", rd, 8'h02);
    access(0, 1'b0, BASE | 8'd4, 8'h00, 0, rd);
    check("oneshot_count_zero", rd, 8'h00);

    // Auto-reload timer: reload 1 -> expiry every 8 cycles
    access(0, 1'b1, BASE | 8'd3, 8'h01, 0, rd);
    access(0, 1'b1, BASE | 8'd2, 8'h07, 0, rd);
    e = last_ack_cnt + 1;
    wait_until(e + 8);
    check("auto_int_not_early", int_req[0], 0);
    wait_until(e + 9);
    check("auto_int_first", int_req[0], 1);
    int_ack[0] = 1'b1;
    @(negedge clkg);
    int_ack[0] = 1'b0;
    wait_until(e + 16);
    check("auto_int_cleared", int_req[0], 0);
    wait_until(e + 17);
    check("auto_int_second", int_req[0], 1);
    wait_until(e + 22);
    access(0, 1'b1, BASE | 8'd5, 8'h01, 0, rd);
    wait_until(e + 26);
    check("status_clear_vs_expiry", int_req[0], 1);
    access(0, 1'b1, BASE | 8'd5, 8'h01, 0, rd);
    wait_until(e + 30);
    check("status_clear_plain", int_req[0], 0);
    access(0, 1'b1, BASE | 8'd2, 8'h00, 0, rd);

    // Three wait states: abort in WAIT, full access, out-of-window access
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE; wdat[1] = 8'h77;
    repeat (2) @(negedge clkg);
    stb[1] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clkg);
      if (ack[1] !== 1'b0) seen = 1;
    end
    check("abort_no_ack", 32'(seen), 0);
    check("abort_led_unchanged", led[1], 8'h00);
    check("abort_state_idle", dbg[1], IDLE);
    cyc[1] = 1'b0; we[1] = 1'b0;
    @(negedge clkg);
    access(1, 1'b1, BASE, 8'h77, 3, rd);
    check("ws3_led_write", led[1], 8'h77);
    access(1, 1'b0, BASE, 8'h00, 3, rd);
    check("ws3_led_read", rd, 8'h77);

    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE + 8'd8; wdat[1] = 8'h11;
    seen = 0;
    repeat (10) begin
      @(negedge clkg);
      if (ack[1] !== 1'b0) seen = 1;
    end
    check("out_of_window_no_ack", 32'(seen), 0);
    check("out_of_window_idle", dbg[1], IDLE);
    check("out_of_window_led", led[1], 8'h77);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    @(negedge clkg);

    // Reset while a TRELOAD write sits in ACK
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = BASE | 8'd3; wdat[0] = 8'h99;
    @(negedge clkg);
    check("pre_reset_ack", ack[0], 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ack", ack[0], 0);
    check("mid_rst_dat", rdat[0], 0);
    check("mid_rst_led", led[0], 0);
    check("mid_rst_led1", led[1], 0);
    check("mid_rst_state", dbg[0], IDLE);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    @(negedge clkg);
    rst = 1'b0;
    @(negedge clkg);
    access(0, 1'b0, BASE | 8'd3, 8'h00, 0, rd);
    check("rst_treload_lost", rd, 8'h00);
    access(0, 1'b0, BASE | 8'd4, 8'h00, 0, rd);
    check("rst_tcount_zero", rd, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
